pos_demux_bank: RTL

POS_DEMUX_BANK -- requirements
Module: pos_demux_bank

---
 rtl/pos_demux_bank_if.sv | 28 ++
 rtl/pos_demux_bank.sv | 91 +++++++++
 2 files changed

// File: rtl/pos_demux_bank_if.sv
// rtl/pos_demux_bank_if.sv - write/clear handshake and slot outputs of the position bank
// master drives requests; slave (the bank) returns readiness, pulses and slot contents.
interface pos_demux_bank_if;
   logic [2:0] S;
   logic [4:0] Din;
   logic       wr_valid;
   logic       wr_ready;
   logic       clr_req;
   logic       clr_done;
   logic       wr_err;
   logic [4:0] Q0;
   logic [4:0] Q1;
   logic [4:0] Q2;
   logic [4:0] Q3;
   logic [4:0] Q4;
   logic [4:0] Q5;
   logic [7:0] upd_cnt;

   modport master (
      output S, Din, wr_valid, clr_req,
      input  wr_ready, clr_done, wr_err, Q0, Q1, Q2, Q3, Q4, Q5, upd_cnt
   );

   modport slave (
      input  S, Din, wr_valid, clr_req,
      output wr_ready, clr_done, wr_err, Q0, Q1, Q2, Q3, Q4, Q5, upd_cnt
   );
endinterface

// File: rtl/pos_demux_bank.sv
// rtl/pos_demux_bank.sv - 6-slot position bank write demux with sequential clear sweep
// Optional RANGE_CHK_EN: reject writes whose Din lies outside the 4x5 board (Din > 19).
module pos_demux_bank #(
   parameter logic [4:0] INIT0 = 5'd0,
   parameter logic [4:0] INIT1 = 5'd1,
   parameter logic [4:0] INIT2 = 5'd2,
   parameter logic [4:0] INIT3 = 5'd3,
   parameter logic [4:0] INIT4 = 5'd4,
   parameter logic [4:0] INIT5 = 5'd5
) (
   input logic             clk,
   input logic             rst,
   pos_demux_bank_if.slave bus
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [4:0] INIT_TAB [6] = '{INIT0, INIT1, INIT2, INIT3, INIT4, INIT5};

   state_t     state;
   logic [2:0] cnt;
   logic [4:0] q [6];
   logic [7:0] upd;
   logic       err_r;
   logic       done_r;
   logic       wr_bad;

   always_comb begin
      wr_bad = (bus.S > 3'd5);
`ifdef RANGE_CHK_EN
      if (bus.Din > 5'd19)
         wr_bad = 1'b1;
`endif
   end

   // a pending clear takes priority, so a simultaneous write is never accepted
   assign bus.wr_ready = (state == IDLE) && !bus.clr_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 3'd0;
         upd    <= 8'd0;
         err_r  <= 1'b0;
         done_r <= 1'b0;
         for (int k = 0; k < 6; k++)
            q[k] <= INIT_TAB[k];
      end else begin
         err_r  <= 1'b0;
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.clr_req) begin
                  state <= CLEAR;
                  cnt   <= 3'd0;
                  upd   <= 8'd0;
               end else if (bus.wr_valid) begin
                  if (wr_bad) begin
                     err_r <= 1'b1;
                  end else begin
                     q[bus.S] <= bus.Din;
                     upd      <= upd + 8'd1;
                  end
               end
            end
            CLEAR: begin
               q[cnt] <= INIT_TAB[cnt];
               if (cnt == 3'd5) begin
                  state  <= IDLE;
                  cnt    <= 3'd0;
                  done_r <= 1'b1;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.wr_err   = err_r;
   assign bus.clr_done = done_r;
   assign bus.upd_cnt  = upd;
   assign bus.Q0       = q[0];
   assign bus.Q1       = q[1];
   assign bus.Q2       = q[2];
   assign bus.Q3       = q[3];
   assign bus.Q4       = q[4];
   assign bus.Q5       = q[5];

endmodule
